// File: rtl/dsp_reset_responder.sv
// Target-side stand-in for the DSP reset handshake: watches host I/O writes to the
// reset port and presents the 8'hAA "ready" byte once a valid reset pulse has completed.
module dsp_reset_responder #(
  parameter logic [15:0]      BASE_ADDRESS     = 16'h0000,
  parameter int unsigned      CNT_W            = 8,
  parameter logic [CNT_W-1:0] MIN_RESET_CYCLES = CNT_W'(24),
  parameter logic [CNT_W-1:0] READY_DELAY      = CNT_W'(16)
) (
  input  logic        bus_clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic        data_avail,
  output logic        reset_active,
  output logic        dsp_ready
);

  localparam logic [15:0]      RESET_PORT  = BASE_ADDRESS + 16'h0006;
  localparam logic [15:0]      DATA_PORT   = BASE_ADDRESS + 16'h000A;
  localparam logic [15:0]      STATUS_PORT = BASE_ADDRESS + 16'h000E;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       READY_BYTE  = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HELD,
    S_DELAY,
    S_READY,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic [CNT_W-1:0] delay_cnt;
  logic [CNT_W-1:0] delay_next;
  logic [7:0]       rd_byte;
  logic [7:0]       rd_byte_next;
  logic [CNT_W:0]   delay_inc;

  logic hit_reset;
  logic hit_data;
  logic hit_status;
  logic start_hold;
  logic end_hold;
  logic consume;
  logic unused_data_bits;

  assign hit_reset  = (address == RESET_PORT);
  assign hit_data   = (address == DATA_PORT);
  assign hit_status = (address == STATUS_PORT);

  // Address and data are a single shared bus, so a simultaneous wr suppresses
  // the read side effect regardless of which port the write targets.
  assign start_hold = wr & hit_reset & data_in[0];
  assign end_hold   = wr & hit_reset & ~data_in[0];
  assign consume    = rd & ~wr & hit_data;

  assign delay_inc        = {1'b0, delay_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign unused_data_bits = ^data_in[15:1];

  always_ff @(posedge bus_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      delay_cnt <= '0;
      rd_byte   <= 8'h00;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      delay_cnt <= delay_next;
      rd_byte   <= rd_byte_next;
    end
  end

  // The hold counter loads 1 on the write-1 edge so that the write-1 edge itself
  // is included in the measured pulse length.
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    delay_next   = delay_cnt;
    rd_byte_next = rd_byte;

    if (start_hold) begin
      state_next   = S_HELD;
      hold_next    = CNT_ONE;
      delay_next   = '0;
      rd_byte_next = 8'h00;
    end else begin
      case (state)
        S_HELD: begin
          if (end_hold) begin
            if (hold_cnt >= MIN_RESET_CYCLES) begin
              state_next = S_DELAY;
              delay_next = '0;
            end else begin
              state_next = S_IDLE;
            end
          end else if (hold_cnt != '1) begin
            hold_next = hold_cnt + CNT_ONE;
          end
        end
        S_DELAY: begin
          if (delay_inc >= {1'b0, READY_DELAY}) begin
            state_next   = S_READY;
            rd_byte_next = READY_BYTE;
          end else begin
            delay_next = delay_inc[CNT_W-1:0];
          end
        end
        S_READY: begin
          if (consume) begin
            state_next = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_avail   = (state == S_READY);
  assign reset_active = (state == S_HELD);
  assign dsp_ready    = (state == S_DONE);

  always_comb begin
    data_oe  = 1'b0;
    data_out = 16'h0000;
    if (reset_n && rd) begin
      if (hit_status) begin
        data_oe  = 1'b1;
        data_out = {8'h00, data_avail, 7'h00};
      end else if (hit_data) begin
        data_oe  = 1'b1;
        data_out = {8'h00, rd_byte};
      end
    end
  end

endmodule

// File: tb/tb_dsp_reset_responder.sv
// Directed bench: two responders share one host bus, one at base 0x000 and one at 0x220,
// so every access also checks that the other decoder ignores it.
module tb_dsp_reset_responder;

  logic        bus_clock = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;

  logic [15:0] data_out_a;
  logic        data_oe_a;
  logic        data_avail_a;
  logic        reset_active_a;
  logic        dsp_ready_a;

  logic [15:0] data_out_b;
  logic        data_oe_b;
  logic        data_avail_b;
  logic        reset_active_b;
  logic        dsp_ready_b;

  int compare_count  = 0;
  int mismatch_count = 0;

  always #5 bus_clock = ~bus_clock;

  dsp_reset_responder dut_a (
    .bus_clock    (bus_clock),
    .reset_n      (reset_n),
    .address      (address),
    .data_in      (data_in),
    .wr           (wr),
    .rd           (rd),
    .data_out     (data_out_a),
    .data_oe      (data_oe_a),
    .data_avail   (data_avail_a),
    .reset_active (reset_active_a),
    .dsp_ready    (dsp_ready_a)
  );

  dsp_reset_responder #(.BASE_ADDRESS(16'h0220)) dut_b (
    .bus_clock    (bus_clock),
    .reset_n      (reset_n),
    .address      (address),
    .data_in      (data_in),
    .wr           (wr),
    .rd           (rd),
    .data_out     (data_out_b),
    .data_oe      (data_oe_b),
    .data_avail   (data_avail_b),
    .reset_active (reset_active_b),
    .dsp_ready    (dsp_ready_b)
  );

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge bus_clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] d);
    address = addr;
    data_in = d;
    wr      = 1'b1;
    tick();
    wr      = 1'b0;
    data_in = 16'h0000;
    address = 16'h0000;
  endtask

  // Write 1, keep it for hold_n edges counting the write-1 edge, then write 0.
  task automatic run_handshake(input logic [15:0] base, input int hold_n);
    apply_stimulus(base + 16'h0006, 16'h0001);
    idle(hold_n - 1);
    apply_stimulus(base + 16'h0006, 16'h0000);
  endtask

  // Combinational read with no clock edge in between.
  task automatic peek_a(input logic [15:0] addr, input logic [15:0] exp_data,
                        input logic exp_oe, input string tag);
    rd      = 1'b1;
    address = addr;
    #2;
    check_output(tag, data_out_a, exp_data);
    check_output({tag, "_oe"}, {15'b0, data_oe_a}, {15'b0, exp_oe});
    rd      = 1'b0;
    address = 16'h0000;
  endtask

  task automatic peek_b(input logic [15:0] addr, input logic [15:0] exp_data,
                        input logic exp_oe, input string tag);
    rd      = 1'b1;
    address = addr;
    #2;
    check_output(tag, data_out_b, exp_data);
    check_output({tag, "_oe"}, {15'b0, data_oe_b}, {15'b0, exp_oe});
    rd      = 1'b0;
    address = 16'h0000;
  endtask

  // Read that is held across a clock edge, so side effects take place.
  task automatic read_a(input logic [15:0] addr, input logic [15:0] exp_data, input string tag);
    rd      = 1'b1;
    address = addr;
    #2;
    check_output(tag, data_out_a, exp_data);
    tick();
    rd      = 1'b0;
    address = 16'h0000;
  endtask

  task automatic read_b(input logic [15:0] addr, input logic [15:0] exp_data, input string tag);
    rd      = 1'b1;
    address = addr;
    #2;
    check_output(tag, data_out_b, exp_data);
    tick();
    rd      = 1'b0;
    address = 16'h0000;
  endtask

  // Flags packed as {data_avail, reset_active, dsp_ready}.
  task automatic flags_a(input string tag, input logic [2:0] expected);
    check_output(tag, {13'b0, data_avail_a, reset_active_a, dsp_ready_a}, {13'b0, expected});
  endtask

  task automatic flags_b(input string tag, input logic [2:0] expected);
    check_output(tag, {13'b0, data_avail_b, reset_active_b, dsp_ready_b}, {13'b0, expected});
  endtask

  initial begin
    reset_n = 1'b0;
    address = 16'h0000;
    data_in = 16'h0000;
    wr      = 1'b0;
    rd      = 1'b0;
    #12;
    flags_a("reset_flags_a", 3'b000);
    flags_b("reset_flags_b", 3'b000);
    check_output("reset_data_out_a", data_out_a, 16'h0000);
    peek_a(16'h000E, 16'h0000, 1'b0, "reset_read_gated");
    reset_n = 1'b1;
    tick();

    $display("[TB] T1 valid 24-cycle reset pulse");
    apply_stimulus(16'h0006, 16'h0001);
    flags_a("t1_held", 3'b010);
    idle(23);
    apply_stimulus(16'h0006, 16'h0000);
    flags_a("t1_delay", 3'b000);
    for (int i = 0; i < 16; i++) begin
      peek_a(16'h000E, 16'h0000, 1'b1, "t1_status_wait");
      tick();
    end
    peek_a(16'h000E, 16'h0080, 1'b1, "t1_status_ready");
    flags_a("t1_ready", 3'b100);
    read_a(16'h000A, 16'h00AA, "t1_read_aa");
    flags_a("t1_done", 3'b001);
    peek_a(16'h000E, 16'h0000, 1'b1, "t1_status_after");
    peek_a(16'h000A, 16'h00AA, 1'b1, "t1_data_done");
    flags_b("t1_b_ignores_006", 3'b000);

    $display("[TB] T2 short pulses are ignored");
    run_handshake(16'h0000, 10);
    flags_a("t2_idle", 3'b000);
    for (int i = 0; i < 100; i++) begin
      peek_a(16'h000E, 16'h0000, 1'b1, "t2_status");
      tick();
    end
    run_handshake(16'h0000, 23);
    idle(20);
    flags_a("t2_hold23_rejected", 3'b000);
    apply_stimulus(16'h0006, 16'h0000);
    flags_a("t2_write0_idle", 3'b000);

    $display("[TB] T3 restart from ready");
    run_handshake(16'h0000, 24);
    idle(16);
    flags_a("t3_ready", 3'b100);
    peek_a(16'h000A, 16'h00AA, 1'b1, "t3_data_ready");
    read_a(16'h000E, 16'h0080, "t3_status_no_effect");
    flags_a("t3_still_ready", 3'b100);
    apply_stimulus(16'h0006, 16'h0001);
    flags_a("t3_rehold", 3'b010);
    peek_a(16'h000A, 16'h0000, 1'b1, "t3_data_cleared");
    read_a(16'h000A, 16'h0000, "t3_read_in_hold");
    flags_a("t3_hold_unchanged", 3'b010);
    run_handshake(16'h0000, 24);
    idle(16);
    flags_a("t3_ready_again", 3'b100);
    peek_a(16'h000A, 16'h00AA, 1'b1, "t3_data_again");

    $display("[TB] T6 simultaneous read and write");
    address = 16'h000A;
    data_in = 16'h0001;
    rd      = 1'b1;
    wr      = 1'b1;
    #2;
    check_output("t6_rd_wr_data", data_out_a, 16'h00AA);
    tick();
    rd = 1'b0;
    wr = 1'b0;
    flags_a("t6_read_suppressed", 3'b100);
    address = 16'h0006;
    data_in = 16'h0001;
    rd      = 1'b1;
    wr      = 1'b1;
    #2;
    check_output("t6_port6_not_readable", {15'b0, data_oe_a}, 16'h0000);
    tick();
    rd      = 1'b0;
    wr      = 1'b0;
    data_in = 16'h0000;
    flags_a("t6_write_wins", 3'b010);

    $display("[TB] T7 long hold saturates");
    run_handshake(16'h0000, 270);
    idle(16);
    flags_a("t7_saturated_ready", 3'b100);

    $display("[TB] T4 asynchronous reset");
    apply_stimulus(16'h0006, 16'h0001);
    flags_a("t4_held", 3'b010);
    #2 reset_n = 1'b0;
    #1;
    flags_a("t4_async_held", 3'b000);
    #1 reset_n = 1'b1;
    tick();
    flags_a("t4_after_release", 3'b000);
    run_handshake(16'h0000, 24);
    idle(5);
    #2 reset_n = 1'b0;
    #1;
    flags_a("t4_async_delay", 3'b000);
    peek_a(16'h000E, 16'h0000, 1'b0, "t4_read_in_reset");
    reset_n = 1'b1;
    idle(30);
    flags_a("t4_no_ready", 3'b000);
    peek_a(16'h000A, 16'h0000, 1'b1, "t4_no_aa");

    $display("[TB] T5 relocated base 0x220");
    run_handshake(16'h0220, 24);
    flags_b("t5_b_delay", 3'b000);
    flags_a("t5_a_ignores", 3'b000);
    peek_b(16'h022E, 16'h0000, 1'b1, "t5_b_status_wait");
    idle(16);
    peek_b(16'h022E, 16'h0080, 1'b1, "t5_b_status_ready");
    peek_b(16'h0006, 16'h0000, 1'b0, "t5_b_006_ignored");
    peek_b(16'h0224, 16'h0000, 1'b0, "t5_b_224_ignored");
    peek_a(16'h022E, 16'h0000, 1'b0, "t5_a_22e_ignored");
    apply_stimulus(16'h0224, 16'h0001);
    flags_b("t5_b_write224_ignored", 3'b100);
    read_b(16'h022A, 16'h00AA, "t5_b_read_aa");
    flags_b("t5_b_done", 3'b001);
    flags_a("t5_a_untouched", 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
